// File: rtl/i2c_reg_target.sv
// I2C target with a 2**AW-byte register file. SCL/SDA are oversampled on clk,
// synchronized and glitch-filtered; SDA is only ever pulled low or released.
module i2c_reg_target #(
  parameter logic [6:0] DEV_ADDR = 7'h69,
  parameter int         AW       = 8,
  parameter int         FILT_LEN = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          scl,
  inout  wire           sda,
  output logic          busy,
  output logic          wr_valid,
  output logic [AW-1:0] wr_addr,
  output logic [7:0]    wr_data
);

  localparam logic [3:0] ST_IDLE     = 4'd0;
  localparam logic [3:0] ST_DEV_ADDR = 4'd1;
  localparam logic [3:0] ST_ACK_A    = 4'd2;
  localparam logic [3:0] ST_REG_ADDR = 4'd3;
  localparam logic [3:0] ST_ACK_R    = 4'd4;
  localparam logic [3:0] ST_WR_DATA  = 4'd5;
  localparam logic [3:0] ST_ACK_W    = 4'd6;
  localparam logic [3:0] ST_RD_DATA  = 4'd7;
  localparam logic [3:0] ST_M_ACK    = 4'd8;

  // A line level is accepted only after FILT_LEN identical samples.
  function automatic logic filt_next(input logic [FILT_LEN-1:0] hist, input logic cur);
    if (&hist) begin
      filt_next = 1'b1;
    end else if (~|hist) begin
      filt_next = 1'b0;
    end else begin
      filt_next = cur;
    end
  endfunction

  logic [1:0]          scl_sync_r;
  logic [1:0]          sda_sync_r;
  logic [FILT_LEN-1:0] scl_hist_r;
  logic [FILT_LEN-1:0] sda_hist_r;
  logic                scl_filt_r;
  logic                sda_filt_r;
  logic                scl_prev_r;
  logic                sda_prev_r;

  logic [3:0]          state_r;
  logic [2:0]          bit_cnt_r;
  logic [7:0]          shift_r;
  logic [AW-1:0]       ptr_r;
  logic                rw_r;
  logic                ack_on_r;
  logic                drive_r;
  logic [7:0]          mem_r [0:(2**AW)-1];

  logic                scl_rise_s;
  logic                scl_fall_s;
  logic                sda_rise_s;
  logic                sda_fall_s;
  logic                start_s;
  logic                stop_s;
  logic                last_bit_s;
  logic [7:0]          byte_s;
  logic [7:0]          rd_byte_s;
  logic [AW-1:0]       ptr_inc_s;
  logic                mem_we_s;

  // Reset gates the pull-down directly so SDA is freed without waiting for a clock.
  assign sda = (drive_r && reset) ? 1'b0 : 1'bz;

  assign scl_rise_s = scl_filt_r & ~scl_prev_r;
  assign scl_fall_s = ~scl_filt_r & scl_prev_r;
  assign sda_rise_s = sda_filt_r & ~sda_prev_r;
  assign sda_fall_s = ~sda_filt_r & sda_prev_r;
  // Qualifying with the current scl level makes a STOP coincident with an scl rise win.
  assign start_s    = sda_fall_s & scl_filt_r;
  assign stop_s     = sda_rise_s & scl_filt_r;
  assign last_bit_s = (bit_cnt_r == 3'd7);
  assign byte_s     = {shift_r[6:0], sda_filt_r};
  assign rd_byte_s  = mem_r[ptr_r];
  assign ptr_inc_s  = ptr_r + {{(AW-1){1'b0}}, 1'b1};
  assign mem_we_s   = (state_r == ST_WR_DATA) && scl_rise_s && last_bit_s && !stop_s && !start_s;

  // Synchronize and filter both bus lines, keeping the previous filtered level for edges.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scl_sync_r <= 2'b11;
      sda_sync_r <= 2'b11;
      scl_hist_r <= {FILT_LEN{1'b1}};
      sda_hist_r <= {FILT_LEN{1'b1}};
      scl_filt_r <= 1'b1;
      sda_filt_r <= 1'b1;
      scl_prev_r <= 1'b1;
      sda_prev_r <= 1'b1;
    end else begin
      scl_sync_r <= {scl_sync_r[0], scl};
      sda_sync_r <= {sda_sync_r[0], sda};
      scl_hist_r <= {scl_hist_r[FILT_LEN-2:0], scl_sync_r[1]};
      sda_hist_r <= {sda_hist_r[FILT_LEN-2:0], sda_sync_r[1]};
      scl_filt_r <= filt_next(scl_hist_r, scl_filt_r);
      sda_filt_r <= filt_next(sda_hist_r, sda_filt_r);
      scl_prev_r <= scl_filt_r;
      sda_prev_r <= sda_filt_r;
    end
  end

  // Protocol FSM: bus events first, then per-state bit handling on filtered scl edges.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= ST_IDLE;
      bit_cnt_r <= 3'd0;
      shift_r   <= 8'h00;
      ptr_r     <= {AW{1'b0}};
      rw_r      <= 1'b0;
      ack_on_r  <= 1'b0;
      drive_r   <= 1'b0;
      busy      <= 1'b0;
      wr_valid  <= 1'b0;
      wr_addr   <= {AW{1'b0}};
      wr_data   <= 8'h00;
    end else begin
      wr_valid <= 1'b0;
      if (stop_s) begin
        state_r   <= ST_IDLE;
        bit_cnt_r <= 3'd0;
        ack_on_r  <= 1'b0;
        drive_r   <= 1'b0;
        busy      <= 1'b0;
      end else if (start_s) begin
        state_r   <= ST_DEV_ADDR;
        bit_cnt_r <= 3'd0;
        ack_on_r  <= 1'b0;
        drive_r   <= 1'b0;
      end else begin
        case (state_r)
          ST_IDLE: begin
            drive_r <= 1'b0;
          end
          ST_DEV_ADDR, ST_REG_ADDR, ST_WR_DATA: begin
            if (scl_rise_s) begin
              shift_r   <= byte_s;
              bit_cnt_r <= bit_cnt_r + 3'd1;
              if (last_bit_s) begin
                case (state_r)
                  ST_DEV_ADDR: begin
                    if (byte_s[7:1] == DEV_ADDR) begin
                      state_r <= ST_ACK_A;
                      rw_r    <= byte_s[0];
                      busy    <= 1'b1;
                    end else begin
                      state_r <= ST_IDLE;
                      busy    <= 1'b0;
                    end
                  end
                  ST_REG_ADDR: begin
                    ptr_r   <= AW'(byte_s);
                    state_r <= ST_ACK_R;
                  end
                  default: begin
                    wr_valid <= 1'b1;
                    wr_addr  <= ptr_r;
                    wr_data  <= byte_s;
                    state_r  <= ST_ACK_W;
                  end
                endcase
              end
            end
          end
          // First scl fall starts the ACK pull-down, the second one ends it.
          ST_ACK_A, ST_ACK_R, ST_ACK_W: begin
            if (scl_fall_s) begin
              ack_on_r <= ~ack_on_r;
              drive_r  <= ~ack_on_r;
              if (ack_on_r) begin
                bit_cnt_r <= 3'd0;
                case (state_r)
                  ST_ACK_A: begin
                    state_r <= ST_REG_ADDR;
                  end
                  ST_ACK_R: begin
                    if (rw_r) begin
                      shift_r <= rd_byte_s;
                      drive_r <= ~rd_byte_s[7];
                      state_r <= ST_RD_DATA;
                    end else begin
                      state_r <= ST_WR_DATA;
                    end
                  end
                  default: begin
                    ptr_r   <= ptr_inc_s;
                    state_r <= ST_WR_DATA;
                  end
                endcase
              end
            end
          end
          ST_RD_DATA: begin
            if (scl_fall_s) begin
              drive_r <= ~shift_r[7];
            end
            if (scl_rise_s) begin
              shift_r   <= {shift_r[6:0], 1'b0};
              bit_cnt_r <= bit_cnt_r + 3'd1;
              if (last_bit_s) begin
                state_r <= ST_M_ACK;
              end
            end
          end
          ST_M_ACK: begin
            if (scl_fall_s) begin
              drive_r <= 1'b0;
            end
            if (scl_rise_s) begin
              if (!sda_filt_r) begin
                ptr_r   <= ptr_inc_s;
                shift_r <= mem_r[ptr_inc_s];
                state_r <= ST_RD_DATA;
              end else begin
                state_r <= ST_IDLE;
                busy    <= 1'b0;
              end
            end
          end
          default: begin
            state_r <= ST_IDLE;
            drive_r <= 1'b0;
          end
        endcase
      end
    end
  end

  // Register file storage; contents intentionally survive reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_r[ptr_r] <= byte_s;
    end
  end

endmodule
